// File: rtl/time_entry_bcd2bin.sv
// Sequential BCD-to-binary converter for the alarm set path.
// Accepts four BCD digits (H-tens, H-ones, M-tens, M-ones) over a valid/ready
// handshake, range-checks the assembled time and publishes binary hours and
// minutes. This is the inverse of the display path's binary-to-BCD split.
module time_entry_bcd2bin #(
   parameter int MAX_HOURS   = 24,  // exclusive bound on hours, 2..32
   parameter int MAX_MINUTES = 60   // exclusive bound on minutes, 2..64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   output logic       digit_ready,
   input  logic       clear,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic       time_valid,
   output logic       entry_error,
   output logic       busy,
   output logic [2:0] digit_count
);

   typedef enum logic [2:0] {
      WAIT_H10,
      WAIT_H1,
      WAIT_M10,
      WAIT_M1,
      CHECK
   } state_t;

   // Limits sized to the accumulator width so the range compare is width-clean.
   localparam logic [6:0] HOUR_LIMIT = 7'(MAX_HOURS);
   localparam logic [6:0] MIN_LIMIT  = 7'(MAX_MINUTES);

   state_t     state;
   logic [6:0] acc_h;
   logic [6:0] acc_m;
   logic [6:0] digit_ext;
   logic       digit_bad;

   // Multiply by ten with shifts and one add; 9*10 = 90 fits in 7 bits.
   function automatic logic [6:0] times10(input logic [6:0] x);
      return (x << 3) + (x << 1);
   endfunction

   assign digit_ext = {3'b000, digit_in};
   assign digit_bad = (digit_in > 4'd9);

   // Ready in every digit-collecting state; CHECK spends its cycle deciding.
   assign digit_ready = (state != CHECK);
   assign busy        = (state != WAIT_H10);

   // Entry FSM: accumulates digits, range-checks, commits or rejects.
   // NOTE: all state here is updated with <= so every register samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= WAIT_H10;
         acc_h       <= '0;
         acc_m       <= '0;
         hours       <= '0;
         minutes     <= '0;
         time_valid  <= 1'b0;
         entry_error <= 1'b0;
         digit_count <= '0;
      end else begin
         // Pulses default low so they never last more than one cycle.
         time_valid  <= 1'b0;
         entry_error <= 1'b0;

         if (clear) begin
            // Abort wins over any digit and over a pending commit.
            state       <= WAIT_H10;
            acc_h       <= '0;
            acc_m       <= '0;
            digit_count <= '0;
         end else if (state == CHECK) begin
            if (acc_h < HOUR_LIMIT && acc_m < MIN_LIMIT) begin
               hours      <= acc_h[4:0];
               minutes    <= acc_m[5:0];
               time_valid <= 1'b1;
            end else begin
               entry_error <= 1'b1;
            end
            state       <= WAIT_H10;
            acc_h       <= '0;
            acc_m       <= '0;
            digit_count <= '0;
         end else if (digit_valid) begin
            if (digit_bad) begin
               // Non-BCD digit: drop the whole entry, keep the last good time.
               entry_error <= 1'b1;
               state       <= WAIT_H10;
               acc_h       <= '0;
               acc_m       <= '0;
               digit_count <= '0;
            end else begin
               digit_count <= digit_count + 3'd1;
               case (state)
                  WAIT_H10: begin
                     acc_h <= digit_ext;
                     state <= WAIT_H1;
                  end
                  WAIT_H1: begin
                     acc_h <= times10(acc_h) + digit_ext;
                     state <= WAIT_M10;
                  end
                  WAIT_M10: begin
                     acc_m <= digit_ext;
                     state <= WAIT_M1;
                  end
                  WAIT_M1: begin
                     acc_m <= times10(acc_m) + digit_ext;
                     state <= CHECK;
                  end
                  default: state <= WAIT_H10;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_time_entry_bcd2bin.sv
// Self-checking bench for time_entry_bcd2bin. Two instances share stimulus:
// one with the default 24-h limit, one with MAX_HOURS=12. A reference model
// builds each entry as a list of decimal digits and pushes the expected
// outcome into a per-instance queue; a monitor pops and compares on pulses.
module tb_time_entry_bcd2bin;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic       clear;

   logic       digit_ready,    digit_ready_12;
   logic [4:0] hours,          hours_12;
   logic [5:0] minutes,        minutes_12;
   logic       time_valid,     time_valid_12;
   logic       entry_error,    entry_error_12;
   logic       busy,           busy_12;
   logic [2:0] digit_count,    digit_count_12;

   time_entry_bcd2bin dut (
      .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
      .digit_ready(digit_ready), .clear(clear), .hours(hours), .minutes(minutes),
      .time_valid(time_valid), .entry_error(entry_error), .busy(busy),
      .digit_count(digit_count)
   );

   time_entry_bcd2bin #(.MAX_HOURS(12), .MAX_MINUTES(60)) dut_12 (
      .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
      .digit_ready(digit_ready_12), .clear(clear), .hours(hours_12),
      .minutes(minutes_12), .time_valid(time_valid_12),
      .entry_error(entry_error_12), .busy(busy_12), .digit_count(digit_count_12)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit ok;
      int h;
      int m;
      int cyc;
   } exp_t;

   exp_t q24[$];
   exp_t q12[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   int ent[$];          // digits of the entry in progress
   bit in_check;        // four digits collected, decision pending
   int pend_h, pend_m;  // assembled time awaiting decision
   int cm_h[2];         // last committed time per instance
   int cm_m[2];
   int last_h[2];       // monitor's view of the published time
   int last_m[2];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int idx, input exp_t e);
      if (idx == 0) q24.push_back(e);
      else          q12.push_back(e);
   endtask

   // Decide an assembled time against each instance's limits.
   task automatic model_decide(input int h, input int m);
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         int   lim;
         lim  = (i == 0) ? 24 : 12;
         e.ok = (h < lim) && (m < 60);
         if (e.ok) begin
            cm_h[i] = h;
            cm_m[i] = m;
         end
         e.h   = cm_h[i];
         e.m   = cm_m[i];
         e.cyc = cyc;
         push_exp(i, e);
      end
   endtask

   task automatic model_reject();
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         e.ok  = 1'b0;
         e.h   = cm_h[i];
         e.m   = cm_m[i];
         e.cyc = cyc;
         push_exp(i, e);
      end
   endtask

   // One clock cycle of stimulus with handshake-status checks beforehand.
   task automatic step(input logic [3:0] d, input bit v, input bit c);
      @(negedge clk);
      digit_in    = d;
      digit_valid = v;
      clear       = c;
      check("digit_ready", int'(digit_ready), in_check ? 0 : 1);
      check("busy", int'(busy), (in_check || ent.size() != 0) ? 1 : 0);
      check("digit_count", int'(digit_count), in_check ? 4 : ent.size());
      check("digit_ready_12", int'(digit_ready_12), in_check ? 0 : 1);
      @(posedge clk);
      #1;
      if (c) begin
         ent.delete();
         in_check = 1'b0;
      end else if (in_check) begin
         model_decide(pend_h, pend_m);
         in_check = 1'b0;
      end else if (v) begin
         if (int'(d) > 9) begin
            model_reject();
            ent.delete();
         end else begin
            ent.push_back(int'(d));
            if (ent.size() == 4) begin
               pend_h   = ent[0] * 10 + ent[1];
               pend_m   = ent[2] * 10 + ent[3];
               in_check = 1'b1;
               ent.delete();
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b0);
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      step(4'(a), 1'b1, 1'b0);
      step(4'(b), 1'b1, 1'b0);
      step(4'(c), 1'b1, 1'b0);
      step(4'(d), 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " hours"}, int'(hours), 0);
      check({tag, " minutes"}, int'(minutes), 0);
      check({tag, " time_valid"}, int'(time_valid), 0);
      check({tag, " entry_error"}, int'(entry_error), 0);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " digit_count"}, int'(digit_count), 0);
      check({tag, " digit_ready"}, int'(digit_ready), 1);
      check({tag, " hours_12"}, int'(hours_12), 0);
   endtask

   task automatic model_reset();
      ent.delete();
      in_check = 1'b0;
      q24.delete();
      q12.delete();
      for (int i = 0; i < 2; i++) begin
         cm_h[i] = 0;
         cm_m[i] = 0;
      end
   endtask

   // Monitor for one instance: compare pulses against the scoreboard queue.
   task automatic mon(input int i, input logic tv, input logic ee,
                      input int h, input int m);
      exp_t e;
      int   qsz;
      if (rst) begin
         last_h[i] = 0;
         last_m[i] = 0;
         return;
      end
      qsz = (i == 0) ? q24.size() : q12.size();
      check($sformatf("pulse exclusive[%0d]", i), int'(tv && ee), 0);
      if (tv || ee) begin
         if (qsz == 0) begin
            check($sformatf("unexpected pulse[%0d]", i), 1, 0);
         end else begin
            e = (i == 0) ? q24.pop_front() : q12.pop_front();
            check($sformatf("pulse cycle[%0d]", i), cyc, e.cyc);
            check($sformatf("time_valid[%0d]", i), int'(tv), int'(e.ok));
            check($sformatf("entry_error[%0d]", i), int'(ee), int'(!e.ok));
            check($sformatf("hours[%0d]", i), h, e.h);
            check($sformatf("minutes[%0d]", i), m, e.m);
            last_h[i] = e.h;
            last_m[i] = e.m;
         end
      end else begin
         check($sformatf("hours held[%0d]", i), h, last_h[i]);
         check($sformatf("minutes held[%0d]", i), m, last_m[i]);
         if (qsz != 0) begin
            e = (i == 0) ? q24[0] : q12[0];
            if (e.cyc < cyc) begin
               check($sformatf("missing pulse[%0d]", i), cyc, e.cyc);
               if (i == 0) void'(q24.pop_front());
               else        void'(q12.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, time_valid, entry_error, int'(hours), int'(minutes));
      mon(1, time_valid_12, entry_error_12, int'(hours_12), int'(minutes_12));
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst         = 1'b1;
      digit_in    = 4'd0;
      digit_valid = 1'b0;
      clear       = 1'b0;
      model_reset();
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // Back-to-back 12:34
      enter(1, 2, 3, 4);
      // Upper boundary, then out-of-range hours
      enter(2, 3, 5, 9);
      enter(2, 4, 0, 0);
      // Illegal digit mid-entry, then a clean entry
      step(4'd1, 1'b1, 1'b0);
      step(4'hA, 1'b1, 1'b0);
      idle(1);
      enter(0, 7, 3, 0);
      // Clear with a simultaneous digit after two digits
      step(4'd1, 1'b1, 1'b0);
      step(4'd2, 1'b1, 1'b0);
      step(4'd3, 1'b1, 1'b1);
      idle(1);
      enter(0, 0, 0, 0);
      // digit_valid held through CHECK
      step(4'd1, 1'b1, 1'b0);
      step(4'd0, 1'b1, 1'b0);
      step(4'd2, 1'b1, 1'b0);
      step(4'd5, 1'b1, 1'b0);
      step(4'd5, 1'b1, 1'b0);
      idle(2);
      // Clear during CHECK aborts the commit
      step(4'd0, 1'b1, 1'b0);
      step(4'd9, 1'b1, 1'b0);
      step(4'd1, 1'b1, 1'b0);
      step(4'd1, 1'b1, 1'b0);
      step(4'd0, 1'b0, 1'b1);
      idle(2);
      // 12-h limit differs from 24-h here
      enter(1, 2, 0, 0);
      enter(1, 1, 5, 9);

      // Asynchronous reset mid-entry
      step(4'd1, 1'b1, 1'b0);
      step(4'd3, 1'b1, 1'b0);
      @(negedge clk);
      digit_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_values("async reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      enter(0, 8, 1, 5);

      // Randomized entries with occasional illegal digits and clears
      for (int n = 0; n < 250; n++) begin
         for (int k = 0; k < 4; k++) begin
            int d;
            if ($urandom_range(0, 3) == 0) idle(1);
            case (k)
               0:       d = $urandom_range(0, 2);
               2:       d = $urandom_range(0, 6);
               default: d = $urandom_range(0, 9);
            endcase
            if ($urandom_range(0, 39) == 0) d = $urandom_range(10, 15);
            step(4'(d), 1'b1, $urandom_range(0, 29) == 0);
         end
         step(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0);
      end

      idle(4);
      check("q24 drained", q24.size(), 0);
      check("q12 drained", q12.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
